psram_qpi_master: RTL and testbench

- Host-side QPI PSRAM controller that converts single-beat memory requests into serial PSRAM transactions driving the external psram device.
- Supports two commands: 0xEB quad read (6 dummy cycles) and 0x38 quad write.
- Sits between the bus-to-PSRAM bridge (valid/ready request, valid/ready response) and the psram pads.
- Generates sck at clock/2 and owns all dio direction control.

---
 rtl/psram_qpi_master.sv | 213 +++++++++++++++++++++
 tb/tb_psram_qpi_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_qpi_master.sv
// QPI PSRAM master: turns one-beat read/write requests into 0xEB quad-read
// or 0x38 quad-write transactions on the PSRAM pads. sck runs at clock/2.
//
// Handshake: on both ports a transfer happens on the rising clock edge
// where valid && ready are both high. The requester holds req_valid and
// the request fields until that edge. The controller holds resp_valid and
// resp_rdata until resp_ready is seen. req_ready and resp_valid are never
// high together.
module psram_qpi_master #(
  parameter int DUMMY_CYCLES = 6,
  parameter int DESEL_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        psram_sck,
  output logic        psram_ce_n,
  output logic [3:0]  psram_dio_o,
  output logic [3:0]  psram_dio_oe,
  input  logic [3:0]  psram_dio_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CMD, S_ADDR, S_WAIT, S_RD, S_WR, S_DESEL, S_RESP
  } state_t;

  localparam logic [7:0] LAST_CMD   = 8'd7;
  localparam logic [7:0] LAST_ADDR  = 8'd5;
  localparam logic [7:0] LAST_WAIT  = 8'(DUMMY_CYCLES - 1);
  localparam logic [7:0] LAST_RD    = 8'd7;
  localparam logic [7:0] LAST_DESEL = 8'(2 * DESEL_CYCLES - 1);

  state_t      state_q, state_d;
  logic        ph_q, ph_d;        // sck phase: 0 = L (drive), 1 = H (device samples)
  logic [7:0]  cnt_q, cnt_d;      // nibble / bit / clock counter, cleared on every transition
  logic        boot_q;            // keeps req_ready low for the first clock after reset
  logic        write_q;
  logic [23:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic [7:0]  phase_last;
  state_t      phase_next;
  logic [7:0]  wr_last;
  logic [7:0]  cmd_byte;
  logic [4:0]  nib_lsb;           // bit position of nibble k within the 32-bit word
  logic [4:0]  addr_lsb;

  assign req_ready  = (state_q == S_IDLE) && boot_q;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign cmd_byte   = write_q ? 8'h38 : 8'hEB;
  // Nibble k: byte k/2, high nibble first.
  assign nib_lsb    = {cnt_q[2:1], ~cnt_q[0], 2'b00};
  assign addr_lsb   = 5'd20 - {cnt_q[2:0], 2'b00};

  // Data-nibble count for writes: 2, 4 or 8 nibbles (size 3 behaves as 4 bytes).
  always_comb begin
    case (size_q)
      2'd0:    wr_last = 8'd1;
      2'd1:    wr_last = 8'd3;
      default: wr_last = 8'd7;
    endcase
  end

  // Length and successor of each sck-clocked phase.
  always_comb begin
    phase_last = 8'd0;
    phase_next = S_IDLE;
    case (state_q)
      S_CMD:  begin phase_last = LAST_CMD;  phase_next = S_ADDR; end
      S_ADDR: begin phase_last = LAST_ADDR; phase_next = write_q ? S_WR : S_WAIT; end
      S_WAIT: begin phase_last = LAST_WAIT; phase_next = S_RD; end
      S_RD:   begin phase_last = LAST_RD;   phase_next = S_DESEL; end
      S_WR:   begin phase_last = wr_last;   phase_next = S_DESEL; end
      default: begin phase_last = 8'd0;     phase_next = S_IDLE; end
    endcase
  end

  // Next-state logic: sck phases advance the counter at the end of phase H.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          ph_d    = 1'b0;
          cnt_d   = 8'd0;
        end
      end
      S_START: begin
        state_d = S_CMD;
        ph_d    = 1'b0;
        cnt_d   = 8'd0;
      end
      S_CMD, S_ADDR, S_WAIT, S_RD, S_WR: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (cnt_q == phase_last) begin
            state_d = phase_next;
            ph_d    = 1'b0;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_DESEL: begin
        ph_d = 1'b0;
        if (cnt_q == LAST_DESEL) begin
          state_d = S_RESP;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State, phase and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ph_q    <= 1'b0;
      cnt_q   <= 8'd0;
      boot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      boot_q  <= 1'b1;
    end
  end

  // Request capture on accept; read nibbles captured as sck returns low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= 24'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      rdata_q <= 32'd0;
    end else if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      size_q  <= req_size;
      rdata_q <= 32'd0;
    end else if (state_q == S_RD && ph_q) begin
      rdata_q[nib_lsb +: 4] <= psram_dio_i;
    end
  end

  // Pad outputs decode straight from the registers so reset releases them at once.
  always_comb begin
    psram_ce_n   = 1'b1;
    psram_sck    = 1'b0;
    psram_dio_o  = 4'h0;
    psram_dio_oe = 4'h0;
    case (state_q)
      S_CMD: begin
        psram_ce_n   = 1'b0;
        psram_sck    = ph_q;
        psram_dio_o  = {3'b000, cmd_byte[3'd7 - cnt_q[2:0]]};
        psram_dio_oe = 4'b0001;
      end
      S_ADDR: begin
        psram_ce_n   = 1'b0;
        psram_sck    = ph_q;
        psram_dio_o  = addr_q[addr_lsb +: 4];
        psram_dio_oe = 4'b1111;
      end
      S_WAIT, S_RD: begin
        psram_ce_n = 1'b0;
        psram_sck  = ph_q;
      end
      S_WR: begin
        psram_ce_n   = 1'b0;
        psram_sck    = ph_q;
        psram_dio_o  = wdata_q[nib_lsb +: 4];
        psram_dio_oe = 4'b1111;
      end
      default: begin
        psram_ce_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_psram_qpi_master.sv
// Bench for psram_qpi_master: a pad-level monitor/device model checks every
// sck nibble against an expected queue and supplies read data; a response
// scoreboard checks data and accept-to-response latency.
module tb_psram_qpi_master;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        psram_sck;
  logic        psram_ce_n;
  logic [3:0]  psram_dio_o;
  logic [3:0]  psram_dio_oe;
  logic [3:0]  psram_dio_i;

  psram_qpi_master #(.DUMMY_CYCLES(6), .DESEL_CYCLES(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .psram_sck    (psram_sck),
    .psram_ce_n   (psram_ce_n),
    .psram_dio_o  (psram_dio_o),
    .psram_dio_oe (psram_dio_oe),
    .psram_dio_i  (psram_dio_i)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];      // expected resp_rdata
  logic [7:0]  exp_nib_q[$];  // expected {oe, dio_o} at each sck rise
  int          exp_rise_q[$]; // expected sck rises per transaction
  int          exp_lat_q[$];  // expected accept-to-resp_valid clocks
  int          acc_q[$];      // clock count just after each accept edge
  logic [3:0]  dev_nib [8];   // read nibbles the device returns
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rise     = 0;
  int          high_run = 0;
  bit          skip     = 1'b0;
  bit          seen_txn = 1'b0;
  logic        prev_sck = 1'b0;
  logic        prev_ce  = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- pad monitor + device model ----------------
  always @(negedge clock) begin
    if (reset) begin
      rise        = 0;
      high_run    = 0;
      skip        = 1'b0;
      seen_txn    = 1'b0;
      prev_sck    = 1'b0;
      prev_ce     = 1'b1;
      psram_dio_i = 4'h0;
    end else begin
      if (!psram_ce_n && psram_sck && !prev_sck) begin
        rise++;
        if (!skip) begin
          if (exp_nib_q.size() == 0) check("nib_unexpected", {24'd0, psram_dio_oe, psram_dio_o}, 32'hFFFF);
          else check("bus_nibble", {24'd0, psram_dio_oe, psram_dio_o}, {24'd0, exp_nib_q.pop_front()});
        end
      end
      if (psram_ce_n && !prev_ce) begin
        if (skip) skip = 1'b0;
        else if (exp_rise_q.size() == 0) check("rise_unexpected", rise, 32'hFFFF);
        else check("sck_count", rise, exp_rise_q.pop_front());
        rise     = 0;
        high_run = 0;
      end
      if (!psram_ce_n && prev_ce) begin
        if (seen_txn) check("desel_gap_ge2", {31'd0, high_run >= 2}, 32'd1);
        seen_txn = 1'b1;
      end
      if (psram_ce_n) high_run++;
      if (!psram_ce_n && rise >= 21 && rise <= 28) psram_dio_i = dev_nib[rise - 21];
      else psram_dio_i = 4'h0;
      prev_sck = psram_sck;
      prev_ce  = psram_ce_n;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input bit wr, input logic [23:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input bit track);
    logic [7:0] cmd;
    int         nbytes;
    bit         ok;
    if (track) begin
      cmd = wr ? 8'h38 : 8'hEB;
      for (int i = 0; i < 8; i++) exp_nib_q.push_back({4'b0001, 3'b000, cmd[7 - i]});
      for (int i = 0; i < 6; i++) exp_nib_q.push_back({4'hF, addr[20 - 4 * i +: 4]});
      if (wr) begin
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int b = 0; b < nbytes; b++) begin
          exp_nib_q.push_back({4'hF, wd[8 * b + 4 +: 4]});
          exp_nib_q.push_back({4'hF, wd[8 * b +: 4]});
        end
        exp_rise_q.push_back(14 + 2 * nbytes);
        exp_lat_q.push_back(2 * (14 + 2 * nbytes) + 3);
        exp_q.push_back(32'd0);
      end else begin
        for (int i = 0; i < 14; i++) exp_nib_q.push_back(8'h00);
        exp_rise_q.push_back(28);
        exp_lat_q.push_back(59);
        exp_q.push_back({dev_nib[6], dev_nib[7], dev_nib[4], dev_nib[5],
                         dev_nib[2], dev_nib[3], dev_nib[0], dev_nib[1]});
      end
    end else begin
      skip = 1'b1;
    end
    @(negedge clock);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_size  = sz;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (track) acc_q.push_back(cyc + 1);
    @(negedge clock);
    req_valid = 1'b0;
    check("ready_drop_on_accept", {31'd0, req_ready}, 32'd0);
    req_write = 1'($urandom_range(0, 1));
    req_addr  = 24'($urandom);
    req_wdata = $urandom;
    req_size  = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_resp(input int hold);
    logic [31:0] d;
    bit          got;
    got = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      if (resp_valid) begin got = 1'b1; break; end
    end
    if (!got) begin
      check("resp_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", cyc - acc_q.pop_front(), exp_lat_q.pop_front());
    d = resp_rdata;
    check("resp_rdata", d, exp_q.pop_front());
    check("ready_with_resp", {31'd0, req_ready}, 32'd0);
    repeat (hold) begin
      @(negedge clock);
      check("resp_hold_valid", {31'd0, resp_valid}, 32'd1);
      check("resp_hold_data", resp_rdata, d);
      check("ready_while_resp", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check("resp_drop", {31'd0, resp_valid}, 32'd0);
    check("ready_after_resp", {31'd0, req_ready}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit done;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 24'd0;
    req_wdata  = 32'd0;
    req_size   = 2'd0;
    resp_ready = 1'b0;
    for (int k = 0; k < 8; k++) dev_nib[k] = 4'(k + 1);
    repeat (3) @(negedge clock);
    check("rst_ce_n", {31'd0, psram_ce_n}, 32'd1);
    check("rst_sck", {31'd0, psram_sck}, 32'd0);
    check("rst_oe", {28'd0, psram_dio_oe}, 32'd0);
    check("rst_dio_o", {28'd0, psram_dio_o}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1 check("ready_at_release", {31'd0, req_ready}, 32'd0);
    @(negedge clock);
    check("ready_after_release", {31'd0, req_ready}, 32'd1);

    // Directed cases
    do_req(1'b1, 24'h000100, 32'hDEADBEEF, 2'd2, 1'b1); wait_resp(0);
    do_req(1'b0, 24'hABCDE4, 32'h0, 2'd0, 1'b1);        wait_resp(2);
    do_req(1'b1, 24'h00F00F, 32'h000000A5, 2'd0, 1'b1); wait_resp(0);
    do_req(1'b1, 24'h123456, 32'h00001234, 2'd1, 1'b1); wait_resp(1);
    do_req(1'b1, 24'h654321, 32'hCAFEF00D, 2'd3, 1'b1); wait_resp(0);

    // Back-to-back with a stalled response
    for (int k = 0; k < 8; k++) dev_nib[k] = 4'($urandom_range(0, 15));
    do_req(1'b1, 24'h0A0B0C, 32'h89ABCDEF, 2'd2, 1'b1);
    fork
      do_req(1'b0, 24'h55AA33, 32'h0, 2'd0, 1'b1);
    join_none
    wait_resp(5);
    wait_resp(0);

    // Reset during read nibble 3
    for (int k = 0; k < 8; k++) dev_nib[k] = 4'($urandom_range(0, 15));
    do_req(1'b0, 24'h777777, 32'h0, 2'd0, 1'b0);
    done = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      #1;
      if (rise == 24) begin done = 1'b1; break; end
    end
    check("reach_rd_nibble3", {31'd0, done}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_ce_n", {31'd0, psram_ce_n}, 32'd1);
    check("abort_oe", {28'd0, psram_dio_oe}, 32'd0);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1 check("abort_ready_release", {31'd0, req_ready}, 32'd0);
    repeat (10) begin
      @(negedge clock);
      check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    for (int k = 0; k < 8; k++) dev_nib[k] = 4'($urandom_range(0, 15));
    do_req(1'b0, 24'h13579B, 32'h0, 2'd0, 1'b1); wait_resp(0);

    // Random mix
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 8; k++) dev_nib[k] = 4'($urandom_range(0, 15));
      do_req(1'($urandom_range(0, 1)), 24'($urandom), $urandom, 2'($urandom_range(0, 3)), 1'b1);
      wait_resp($urandom_range(0, 3));
    end

    repeat (10) @(negedge clock);
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("nib_q_empty", exp_nib_q.size(), 32'd0);
    check("rise_q_empty", exp_rise_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
